// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALUOp/Funct, selects operand B, and hands out a registered {ALUControl, A, B} beat.
// Two-entry skid buffer; optional statistics counters when ALU_ISSUE_STATS_EN is defined.
module alu_issue_stage #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               InValid,
  output logic               InReady,
  input  logic [1:0]         ALUOp,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               ALUSrc,
  input  logic [WIDTH-1:0]   RsData,
  input  logic [WIDTH-1:0]   RtData,
  input  logic [WIDTH-1:0]   Imm,
  input  logic               Flush,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [3:0]         ALUControl,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
`ifdef ALU_ISSUE_STATS_EN
  output logic [15:0]        IssueCount,
  output logic [15:0]        IllegalCount,
`endif
  output logic               IllegalOp
);

  localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_SLT = FUNCT_W'(6'b101010);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  typedef struct packed {
    logic [3:0]       ctrl;
    logic             ill;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } beat_t;

  // Returns {illegal, ALUControl}.
  function automatic logic [4:0] decode(input logic [1:0] op, input logic [FUNCT_W-1:0] fn);
    logic [4:0] r;
    r = {1'b0, 4'b0000};
    case (op)
      2'b00: r = {1'b0, 4'b0010};
      2'b01: r = {1'b0, 4'b0110};
      2'b11: r = {1'b0, 4'b0001};
      2'b10: begin
        if (fn == F_ADD)      r = {1'b0, 4'b0010};
        else if (fn == F_SUB) r = {1'b0, 4'b0110};
        else if (fn == F_AND) r = {1'b0, 4'b0000};
        else if (fn == F_OR)  r = {1'b0, 4'b0001};
        else if (fn == F_SLT) r = {1'b0, 4'b0111};
        else                  r = {1'b1, 4'b0000};
      end
      default: r = {1'b1, 4'b0000};
    endcase
    return r;
  endfunction

  state_t     state_q, state_d;
  beat_t      main_q, main_d, skid_q, skid_d, in_beat;
  logic       in_ready_q;
  logic       in_xfer, out_xfer;
  logic [4:0] dec;

  assign dec          = decode(ALUOp, Funct);
  assign in_beat.ctrl = dec[3:0];
  assign in_beat.ill  = dec[4];
  assign in_beat.a    = RsData;
  assign in_beat.b    = ALUSrc ? Imm : RtData;

  assign in_xfer  = InValid && in_ready_q;
  assign out_xfer = OutValid && OutReady;

  assign InReady    = in_ready_q;
  assign OutValid   = (state_q != EMPTY);
  assign ALUControl = main_q.ctrl;
  assign A          = main_q.a;
  assign B          = main_q.b;
  assign IllegalOp  = main_q.ill;

  // Next-state and buffer steering; flush overrides every transfer.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush) begin
      state_d    = EMPTY;
      main_d.ill = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = in_beat;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_beat;
          end else if (in_xfer) begin
            state_d = TWO;
            skid_d  = in_beat;
          end else if (out_xfer) begin
            state_d    = EMPTY;
            main_d.ill = 1'b0;
          end else begin
            state_d = ONE;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
          end else begin
            state_d = TWO;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
        end
      endcase
    end
  end

  // Occupancy, payload and registered ready.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != TWO);
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] issue_cnt_q, illegal_cnt_q;

  // Counters survive flush and wrap naturally at 16 bits.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      issue_cnt_q   <= 16'd0;
      illegal_cnt_q <= 16'd0;
    end else if (out_xfer && !Flush) begin
      issue_cnt_q   <= issue_cnt_q + 16'd1;
      illegal_cnt_q <= illegal_cnt_q + {15'd0, main_q.ill};
    end else begin
      issue_cnt_q   <= issue_cnt_q;
      illegal_cnt_q <= illegal_cnt_q;
    end
  end

  assign IssueCount   = issue_cnt_q;
  assign IllegalCount = illegal_cnt_q;
`endif

endmodule
